mem_request_unit: RTL and testbench
===================================

# mem_request_unit

Serializes instruction-fetch and load/store requests onto the core's single word-addressed memory port, which has a one-cycle registered read. Sits between the fetch stage / datapath and the memory module. Handles byte and halfword loads (lane extract, sign/zero extend) and stores (read-modify-write). Drives a pipeline stall while a data access is outstanding.

## Interface
- ADDR_W, 16, byte-address width
- DATA_W, 32, word width; fixed at 32
- NOP, 32'h00000013, instruction value driven on `if_instr` at reset
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- if_req  in  1  fetch request; held until `if_valid`
- if_addr  in  ADDR_W  fetch byte address; `[1:0]` ignored
- if_instr  out  32  fetched instruction, registered
- if_valid  out  1  one-cycle pulse; `if_instr` valid
- dm_load, dm_store  in  1  data request; held until `dm_done`; both high is treated as a store
- dm_addr  in  ADDR_W  data byte address
- dm_size  in  2  00 byte, 01 half, 10 word; 11 is treated as word
- dm_unsigned  in  1  zero-extend subword loads
- dm_wdata  in  32  store data, right-aligned
- dm_rdata  out  32  load result, registered
- dm_done  out  1  one-cycle pulse; data access complete
- dm_misalign  out  1  pulses with `dm_done` when the access was rejected
- stall  out  1  combinational: `(dm_load|dm_store) & ~dm_done`
- mem_addr  out  ADDR_W  word address `{2'b0, addr[ADDR_W-1:2]}`, registered
- mem_read_en, mem_write_en  out  1  registered strobes
- mem_wdata  out  32  registered
- mem_rdata  in  32  memory read data, valid the cycle after the edge that sampled `mem_read_en`

## Operation
- **States:** IDLE, IF_RD, IF_WAIT, LD_RD, LD_WAIT, ST_RD, ST_WAIT, ST_WR.
- **Priority in IDLE:** data request beats fetch. An in-flight fetch is never aborted; a data request arriving during a fetch is served next.
- **Misalignment:**
  - A half at offset 3 is misaligned.
  - A word at a nonzero offset is misaligned.
  - A misaligned access makes no memory access: IDLE pulses `dm_done` and `dm_misalign` on the next cycle.
  - `dm_rdata` is unchanged.
- **Fetch:** IDLE → IF_RD (`mem_read_en`=1, `mem_addr`=word of `if_addr`) → IF_WAIT → capture `mem_rdata` into `if_instr`, pulse `if_valid`, → IDLE.
- **Load:** IDLE → LD_RD (read strobe) → LD_WAIT → extract lane `addr[1:0]` (byte lane = `addr[1:0]`*8; half lane = `addr[1]`*16), then extend:
  - sign-extend unless `dm_unsigned`;
  - word loads are passed through unchanged.
  - Register the result to `dm_rdata`, pulse `dm_done`, → IDLE.
- **Word store:** IDLE → ST_WR (`mem_write_en`=1, `mem_wdata`=`dm_wdata`) → IDLE with `dm_done` pulse.
- **Subword store:** IDLE → ST_RD → ST_WAIT (capture old word) → ST_WR.
  - ST_WR writes the merged word: the selected byte/half lane is replaced by `dm_wdata[7:0]` / `[15:0]`; other bytes are preserved.
  - Then → IDLE with `dm_done`.
- `mem_*` strobes are high for exactly one cycle per state entry. They are never both high.
- Reset (any state): state IDLE. All outputs are 0, except `if_instr`=NOP. The `stall` equation still applies during reset.

## Timing
- Request sampled at edge 0 in IDLE:
  - fetch: `if_valid` high in the cycle after edge 2;
  - load: `dm_done` high in the cycle after edge 2;
  - word store: `dm_done` high after edge 1, with the write strobe high that same cycle;
  - subword store: `dm_done` high after edge 3.
- IDLE is re-entered together with the done/valid pulse. A still-high request is re-sampled at that edge as a new request, so the requester must drop it in the done cycle.
- Back-to-back fetches: one instruction per 3 cycles.
- `stall` falls in the `dm_done` cycle. A data request pending behind a fetch keeps `stall` high through the fetch.
- Reset deassertion mid-operation: the first request is sampled at the first edge after release. No partial write is ever emitted after reset.

## Test plan
- Reset mid-ST_RD → all outputs 0, `if_instr`=0x00000013; after release, `mem_write_en` never pulses until a new store.
- Fetch at `if_addr`=0x0010 with memory word 4 = 0x00A00093 → `mem_addr`=0x0004, `if_instr`=0x00A00093, `if_valid` after edge 2.
- Load byte at 0x0103, old word 0x80FF1234, signed then unsigned → `dm_rdata`=0xFFFFFF80, then 0x00000080; `stall` high 3 cycles each.
- Store half 0xBEEF at 0x0202 over word 0x11223344 → write 0xBEEF3344 to `mem_addr` 0x0080, `dm_done` after edge 3; store word at 0x0204 → single write, done after edge 1.
- `dm_load` and `if_req` raised the same cycle → load served first, fetch completes 3 cycles after `dm_done`; data request raised during IF_WAIT → waits, `stall` held.
- Load word at 0x0006 → `dm_done` + `dm_misalign` after edge 1, no `mem_read_en`, `dm_rdata` unchanged.

Source files
------------

// File: rtl/mem_request_unit.sv
// Serializes fetch and load/store requests onto a single word-addressed memory
// port with a one-cycle registered read; subword stores use read-modify-write.
module mem_request_unit #(
    parameter int          ADDR_W = 16,
    parameter int          DATA_W = 32,
    parameter logic [31:0] NOP    = 32'h00000013
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_instr,
    output logic              if_valid,
    input  logic              dm_load,
    input  logic              dm_store,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [1:0]        dm_size,
    input  logic              dm_unsigned,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              dm_done,
    output logic              dm_misalign,
    output logic              stall,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_read_en,
    output logic              mem_write_en,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    // state   | meaning
    // IDLE    | accept a request (data before fetch); finish a rejected access
    // IF_RD   | fetch read strobe on the port
    // IF_WAIT | fetch data returning; capture instruction
    // LD_RD   | load read strobe on the port
    // LD_WAIT | load data returning; extract lane and extend
    // ST_RD   | subword store: read old word
    // ST_WAIT | subword store: capture old word
    // ST_WR   | write strobe issued on exit, together with dm_done
    typedef enum logic [2:0] {
        IDLE, IF_RD, IF_WAIT, LD_RD, LD_WAIT, ST_RD, ST_WAIT, ST_WR
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic              mem_read_en_q, mem_read_en_d;
    logic              mem_write_en_q, mem_write_en_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [DATA_W-1:0] if_instr_q, if_instr_d;
    logic              if_valid_q, if_valid_d;
    logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;
    logic              dm_done_q, dm_done_d;
    logic              dm_misalign_q, dm_misalign_d;
    logic [DATA_W-1:0] old_word_q, old_word_d;
    logic              mis_pend_q, mis_pend_d;

    logic              dm_req;
    logic              size_word;
    logic              misalign;
    logic [ADDR_W-1:0] dm_word_addr;
    logic [ADDR_W-1:0] if_word_addr;
    logic [7:0]        ld_byte;
    logic [15:0]       ld_half;
    logic              unused_if_offset;

    assign dm_req       = dm_load | dm_store;
    assign size_word    = dm_size[1];
    assign misalign     = (dm_size == 2'b01 && dm_addr[1:0] == 2'b11) ||
                          (size_word && dm_addr[1:0] != 2'b00);
    assign dm_word_addr = {2'b00, dm_addr[ADDR_W-1:2]};
    assign if_word_addr = {2'b00, if_addr[ADDR_W-1:2]};
    assign ld_byte      = mem_rdata[{dm_addr[1:0], 3'b000} +: 8];
    assign ld_half      = mem_rdata[{dm_addr[1], 4'b0000} +: 16];
    assign unused_if_offset = ^if_addr[1:0];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q        <= IDLE;
            mem_addr_q     <= '0;
            mem_read_en_q  <= 1'b0;
            mem_write_en_q <= 1'b0;
            mem_wdata_q    <= '0;
            if_instr_q     <= NOP;
            if_valid_q     <= 1'b0;
            dm_rdata_q     <= '0;
            dm_done_q      <= 1'b0;
            dm_misalign_q  <= 1'b0;
            old_word_q     <= '0;
            mis_pend_q     <= 1'b0;
        end else begin
            state_q        <= state_d;
            mem_addr_q     <= mem_addr_d;
            mem_read_en_q  <= mem_read_en_d;
            mem_write_en_q <= mem_write_en_d;
            mem_wdata_q    <= mem_wdata_d;
            if_instr_q     <= if_instr_d;
            if_valid_q     <= if_valid_d;
            dm_rdata_q     <= dm_rdata_d;
            dm_done_q      <= dm_done_d;
            dm_misalign_q  <= dm_misalign_d;
            old_word_q     <= old_word_d;
            mis_pend_q     <= mis_pend_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (mis_pend_q) begin
                    state_d = IDLE;
                end else if (dm_req && !misalign) begin
                    if (dm_store) state_d = size_word ? ST_WR : ST_RD;
                    else          state_d = LD_RD;
                end else if (!dm_req && if_req) begin
                    state_d = IF_RD;
                end
            end
            IF_RD:   state_d = IF_WAIT;
            IF_WAIT: state_d = IDLE;
            LD_RD:   state_d = LD_WAIT;
            LD_WAIT: state_d = IDLE;
            ST_RD:   state_d = ST_WAIT;
            ST_WAIT: state_d = ST_WR;
            ST_WR:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        mem_addr_d     = mem_addr_q;
        mem_read_en_d  = 1'b0;
        mem_write_en_d = 1'b0;
        mem_wdata_d    = mem_wdata_q;
        if_instr_d     = if_instr_q;
        if_valid_d     = 1'b0;
        dm_rdata_d     = dm_rdata_q;
        dm_done_d      = 1'b0;
        dm_misalign_d  = 1'b0;
        old_word_d     = old_word_q;
        mis_pend_d     = 1'b0;
        case (state_q)
            IDLE: begin
                if (mis_pend_q) begin
                    dm_done_d     = 1'b1;
                    dm_misalign_d = 1'b1;
                end else if (dm_req) begin
                    if (misalign) begin
                        mis_pend_d = 1'b1;
                    end else if (!(dm_store && size_word)) begin
                        mem_read_en_d = 1'b1;
                        mem_addr_d    = dm_word_addr;
                    end
                end else if (if_req) begin
                    mem_read_en_d = 1'b1;
                    mem_addr_d    = if_word_addr;
                end
            end
            IF_WAIT: begin
                if_instr_d = mem_rdata;
                if_valid_d = 1'b1;
            end
            LD_WAIT: begin
                case (dm_size)
                    2'b00:   dm_rdata_d = {{24{ld_byte[7] & ~dm_unsigned}}, ld_byte};
                    2'b01:   dm_rdata_d = {{16{ld_half[15] & ~dm_unsigned}}, ld_half};
                    default: dm_rdata_d = mem_rdata;
                endcase
                dm_done_d = 1'b1;
            end
            ST_WAIT: old_word_d = mem_rdata;
            ST_WR: begin
                mem_write_en_d = 1'b1;
                mem_addr_d     = dm_word_addr;
                if (size_word) begin
                    mem_wdata_d = dm_wdata;
                end else begin
                    mem_wdata_d = old_word_q;
                    if (dm_size[0])
                        mem_wdata_d[{dm_addr[1], 4'b0000} +: 16] = dm_wdata[15:0];
                    else
                        mem_wdata_d[{dm_addr[1:0], 3'b000} +: 8] = dm_wdata[7:0];
                end
                dm_done_d = 1'b1;
            end
            default: ;
        endcase
    end

    assign if_instr     = if_instr_q;
    assign if_valid     = if_valid_q;
    assign dm_rdata     = dm_rdata_q;
    assign dm_done      = dm_done_q;
    assign dm_misalign  = dm_misalign_q;
    assign stall        = dm_req & ~dm_done_q;
    assign mem_addr     = mem_addr_q;
    assign mem_read_en  = mem_read_en_q;
    assign mem_write_en = mem_write_en_q;
    assign mem_wdata    = mem_wdata_q;

endmodule

// File: tb/tb_mem_request_unit.sv
// Directed bench for mem_request_unit with a small word memory model behind the port.
module tb_mem_request_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        if_req = 1'b0;
    logic [15:0] if_addr = '0;
    logic [31:0] if_instr;
    logic        if_valid;
    logic        dm_load = 1'b0;
    logic        dm_store = 1'b0;
    logic [15:0] dm_addr = '0;
    logic [1:0]  dm_size = '0;
    logic        dm_unsigned = 1'b0;
    logic [31:0] dm_wdata = '0;
    logic [31:0] dm_rdata;
    logic        dm_done;
    logic        dm_misalign;
    logic        stall;
    logic [15:0] mem_addr;
    logic        mem_read_en;
    logic        mem_write_en;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata = '0;

    logic [31:0] mem [0:1023];
    logic        pl_en = 1'b0;
    logic [9:0]  pl_addr = '0;
    logic [31:0] pl_data = '0;
    int          wr_cnt = 0;
    int          rd_cnt = 0;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mem_request_unit dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_instr(if_instr), .if_valid(if_valid),
        .dm_load(dm_load), .dm_store(dm_store), .dm_addr(dm_addr), .dm_size(dm_size),
        .dm_unsigned(dm_unsigned), .dm_wdata(dm_wdata), .dm_rdata(dm_rdata),
        .dm_done(dm_done), .dm_misalign(dm_misalign), .stall(stall),
        .mem_addr(mem_addr), .mem_read_en(mem_read_en), .mem_write_en(mem_write_en),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    // Memory with one-cycle registered read; preload port used only during reset.
    always @(posedge clk) begin
        if (pl_en) mem[pl_addr] <= pl_data;
        if (mem_read_en) begin
            mem_rdata <= mem[mem_addr[9:0]];
            rd_cnt    <= rd_cnt + 1;
        end
        if (mem_write_en) begin
            mem[mem_addr[9:0]] <= mem_wdata;
            wr_cnt <= wr_cnt + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input logic [9:0] a, input logic [31:0] d);
        pl_en = 1'b1; pl_addr = a; pl_data = d;
        tick();
        pl_en = 1'b0;
    endtask

    task automatic run_load(input string tag, input logic [15:0] a, input logic [1:0] sz,
                            input logic uns, input logic [31:0] exp);
        dm_load = 1'b1; dm_addr = a; dm_size = sz; dm_unsigned = uns;
        #1;
        check({tag, "_stall0"}, {31'b0, stall}, 32'd1);
        tick();
        check({tag, "_rd"}, {31'b0, mem_read_en}, 32'd1);
        check({tag, "_addr"}, {16'b0, mem_addr}, {18'b0, a[15:2]});
        check({tag, "_stall1"}, {31'b0, stall}, 32'd1);
        tick();
        check({tag, "_stall2"}, {31'b0, stall}, 32'd1);
        check({tag, "_nodone"}, {31'b0, dm_done}, 32'd0);
        tick();
        check({tag, "_done"}, {31'b0, dm_done}, 32'd1);
        check({tag, "_rdata"}, dm_rdata, exp);
        check({tag, "_stall3"}, {31'b0, stall}, 32'd0);
        dm_load = 1'b0;
        tick();
        check({tag, "_pulse"}, {31'b0, dm_done}, 32'd0);
    endtask

    int w0;
    int r0;

    initial begin
        // Reset state, stall still combinational during reset
        #2;
        preload(10'h004, 32'h00A00093);
        preload(10'h040, 32'h80FF1234);
        preload(10'h080, 32'h11223344);
        preload(10'h081, 32'h00000000);
        check("rst_if_instr", if_instr, 32'h00000013);
        check("rst_outs", {if_valid, dm_done, dm_misalign, mem_read_en, mem_write_en}, 32'd0);
        check("rst_rdata", dm_rdata, 32'd0);
        check("rst_wdata", mem_wdata, 32'd0);
        check("rst_maddr", {16'b0, mem_addr}, 32'd0);
        dm_load = 1'b1;
        #1;
        check("rst_stall", {31'b0, stall}, 32'd1);
        dm_load = 1'b0;
        #1;
        rst = 1'b1;
        tick();

        // Reset asserted in the middle of a subword store
        dm_store = 1'b1; dm_size = 2'b01; dm_addr = 16'h0202; dm_wdata = 32'h0000BEEF;
        tick();
        check("strd_rd", {31'b0, mem_read_en}, 32'd1);
        rst = 1'b0;
        #1;
        check("mid_rst_rd", {31'b0, mem_read_en}, 32'd0);
        check("mid_rst_maddr", {16'b0, mem_addr}, 32'd0);
        check("mid_rst_instr", if_instr, 32'h00000013);
        check("mid_rst_stall", {31'b0, stall}, 32'd1);
        dm_store = 1'b0;
        tick();
        rst = 1'b1;
        w0 = wr_cnt;
        repeat (6) tick();
        check("post_rst_nowr", wr_cnt, w0);
        check("post_rst_nodone", {31'b0, dm_done}, 32'd0);

        // Fetch
        if_req = 1'b1; if_addr = 16'h0010;
        tick();
        check("if_rd", {31'b0, mem_read_en}, 32'd1);
        check("if_maddr", {16'b0, mem_addr}, 32'h0004);
        tick();
        check("if_novalid", {31'b0, if_valid}, 32'd0);
        tick();
        check("if_valid", {31'b0, if_valid}, 32'd1);
        check("if_instr", if_instr, 32'h00A00093);
        if_req = 1'b0;
        tick();
        check("if_pulse", {31'b0, if_valid}, 32'd0);

        // Loads
        run_load("lb_s", 16'h0103, 2'b00, 1'b0, 32'hFFFFFF80);
        run_load("lb_u", 16'h0103, 2'b00, 1'b1, 32'h00000080);
        run_load("lh_s", 16'h0102, 2'b01, 1'b0, 32'hFFFF80FF);
        run_load("lh_u", 16'h0100, 2'b01, 1'b1, 32'h00001234);
        run_load("lw", 16'h0100, 2'b10, 1'b0, 32'h80FF1234);

        // Subword store (half)
        w0 = wr_cnt;
        dm_store = 1'b1; dm_size = 2'b01; dm_addr = 16'h0202; dm_wdata = 32'h0000BEEF;
        tick();
        check("sh_rd", {31'b0, mem_read_en}, 32'd1);
        check("sh_rdaddr", {16'b0, mem_addr}, 32'h0080);
        tick();
        tick();
        check("sh_nowr2", {31'b0, mem_write_en}, 32'd0);
        check("sh_nodone2", {31'b0, dm_done}, 32'd0);
        tick();
        check("sh_wr", {31'b0, mem_write_en}, 32'd1);
        check("sh_done", {31'b0, dm_done}, 32'd1);
        check("sh_waddr", {16'b0, mem_addr}, 32'h0080);
        check("sh_wdata", mem_wdata, 32'hBEEF3344);
        check("sh_stall", {31'b0, stall}, 32'd0);
        dm_store = 1'b0;
        tick();
        check("sh_mem", mem[10'h080], 32'hBEEF3344);

        // Subword store (byte, lane 1)
        dm_store = 1'b1; dm_size = 2'b00; dm_addr = 16'h0201; dm_wdata = 32'hFFFFFF5A;
        repeat (4) tick();
        check("sb_done", {31'b0, dm_done}, 32'd1);
        check("sb_wdata", mem_wdata, 32'hBEEF5A44);
        dm_store = 1'b0;
        tick();

        // Word store
        dm_store = 1'b1; dm_size = 2'b10; dm_addr = 16'h0204; dm_wdata = 32'hCAFEF00D;
        tick();
        check("sw_nostrobe", {30'b0, mem_write_en, mem_read_en}, 32'd0);
        tick();
        check("sw_wr", {31'b0, mem_write_en}, 32'd1);
        check("sw_done", {31'b0, dm_done}, 32'd1);
        check("sw_waddr", {16'b0, mem_addr}, 32'h0081);
        check("sw_wdata", mem_wdata, 32'hCAFEF00D);
        dm_store = 1'b0;
        tick();
        check("st_wrcount", wr_cnt - w0, 32'd3);

        // Load and fetch raised together: load first, fetch 3 cycles after done
        dm_load = 1'b1; dm_addr = 16'h0100; dm_size = 2'b10; if_req = 1'b1; if_addr = 16'h0010;
        tick();
        check("pri_addr", {16'b0, mem_addr}, 32'h0040);
        tick();
        tick();
        check("pri_done", {31'b0, dm_done}, 32'd1);
        check("pri_rdata", dm_rdata, 32'h80FF1234);
        check("pri_noif", {31'b0, if_valid}, 32'd0);
        dm_load = 1'b0;
        tick();
        check("pri_if_addr", {16'b0, mem_addr}, 32'h0004);
        tick();
        tick();
        check("pri_if_valid", {31'b0, if_valid}, 32'd1);
        check("pri_if_instr", if_instr, 32'h00A00093);
        if_req = 1'b0;
        tick();

        // Data request arriving during IF_WAIT waits for the fetch
        if_req = 1'b1;
        tick();
        tick();
        dm_load = 1'b1; dm_addr = 16'h0103; dm_size = 2'b00; dm_unsigned = 1'b1;
        tick();
        check("late_if_valid", {31'b0, if_valid}, 32'd1);
        check("late_stall_a", {31'b0, stall}, 32'd1);
        if_req = 1'b0;
        tick();
        check("late_ld_rd", {31'b0, mem_read_en}, 32'd1);
        check("late_stall_b", {31'b0, stall}, 32'd1);
        tick();
        tick();
        check("late_done", {31'b0, dm_done}, 32'd1);
        check("late_rdata", dm_rdata, 32'h00000080);
        dm_load = 1'b0;
        tick();

        // Misaligned word load: no memory access, rdata held
        r0 = rd_cnt;
        dm_load = 1'b1; dm_addr = 16'h0006; dm_size = 2'b10; dm_unsigned = 1'b0;
        tick();
        check("mis_nodone0", {31'b0, dm_done}, 32'd0);
        check("mis_stall0", {31'b0, stall}, 32'd1);
        tick();
        check("mis_done", {30'b0, dm_done, dm_misalign}, 32'd3);
        check("mis_rdata", dm_rdata, 32'h00000080);
        check("mis_stall1", {31'b0, stall}, 32'd0);
        dm_load = 1'b0;
        tick();
        check("mis_pulse", {30'b0, dm_done, dm_misalign}, 32'd0);
        check("mis_noread", rd_cnt - r0, 32'd0);

        // Misaligned half store at offset 3: no write
        w0 = wr_cnt;
        dm_store = 1'b1; dm_addr = 16'h0203; dm_size = 2'b01; dm_wdata = 32'h00001111;
        tick();
        tick();
        check("mish_done", {30'b0, dm_done, dm_misalign}, 32'd3);
        dm_store = 1'b0;
        repeat (3) tick();
        check("mish_nowr", wr_cnt - w0, 32'd0);
        check("mish_mem", mem[10'h080], 32'hBEEF5A44);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
